// File: rtl/hld_ctrl_pkg.sv
// Shared types and constants for the hold-control pulse generator.
package hld_ctrl_pkg;

  typedef enum logic [1:0] {
    BCAST = 2'b00,
    RR    = 2'b01,
    GATED = 2'b10,
    RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/hld_period_cnt.sv
// Period counter: wraps to 0 after div_eff-1 and flags the terminal count.
// The next value is exported so the owner can register outputs that match it.
module hld_period_cnt #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIV_W-1:0] div_eff,
  output logic [DIV_W-1:0] cnt_next,
  output logic             term
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign term = (cnt_q == div_eff - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = term ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next = cnt_d;

endmodule

// File: rtl/hld_ctrl_gen.sv
// Multi-channel hold-control pulse generator with shadowed configuration
// applied only at start or at period boundaries.
module hld_ctrl_gen
  import hld_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div_n,
  input  logic [DIV_W-1:0]  pw,
  input  logic              div_m,
  input  logic              upd,
  output logic [NUM_CH-1:0] ctrl_hld,
  output logic              frame,
  output logic              cfg_ack,
  output logic              busy
);

  localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    mode_e            mode;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pw;
  } cfg_t;

  function automatic logic [DIV_W-1:0] div_eff_f(input cfg_t c);
    return (c.div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : c.div;
  endfunction

  // Clamp leaves at least one low cycle in every period.
  function automatic logic [DIV_W-1:0] pw_eff_f(input cfg_t c);
    logic [DIV_W-1:0] lim;
    lim = div_eff_f(c) - DIV_W'(1);
    return (c.pw < lim) ? c.pw : lim;
  endfunction

  state_e            state_q, state_d;
  cfg_t              act_q, act_d;
  cfg_t              pend_cfg_q, pend_cfg_d;
  logic              pend_q, pend_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic              divm_q, divm_d;
  logic [NUM_CH-1:0] ctrl_hld_q, ctrl_hld_d;
  logic              frame_q, frame_d;
  logic              cfg_ack_q, cfg_ack_d;
  logic              busy_q, busy_d;

  logic [DIV_W-1:0]  cnt_next;
  logic              term;
  logic              start, wrap, cont, apply, pulse_on;

  hld_period_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == IDLE),
    .adv      (state_q != IDLE),
    .div_eff  (div_eff_f(act_q)),
    .cnt_next (cnt_next),
    .term     (term)
  );

  always_comb begin
    pend_cfg_d = pend_cfg_q;
    if (upd) begin
      pend_cfg_d = '{mode: mode_e'(mode), div: div_n, pw: pw};
    end

    start = (state_q == IDLE) && en;
    wrap  = (state_q != IDLE) && term;
    cont  = start || (wrap && en);
    // A strobe landing on the applying edge is taken straight away.
    apply = cont && (pend_q || upd);

    act_d     = apply ? pend_cfg_d : act_q;
    pend_d    = apply ? 1'b0 : (pend_q || upd);
    cfg_ack_d = apply;

    rr_d = rr_q;
    if (apply && (pend_cfg_d.mode != act_q.mode)) begin
      rr_d = '0;
    end else if (wrap && en) begin
      rr_d = (rr_q == RR_W'(NUM_CH - 1)) ? '0 : rr_q + RR_W'(1);
    end

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? RUN : IDLE;
      RUN,
      DRAIN:   state_d = en ? RUN : (term ? IDLE : DRAIN);
      default: state_d = IDLE;
    endcase

    divm_d   = div_m;
    busy_d   = (state_d != IDLE);
    frame_d  = busy_d && (cnt_next == '0);
    pulse_on = busy_d && (cnt_next < pw_eff_f(act_d));
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    always_comb begin
      ctrl_hld_d[gi] = 1'b0;
      if (pulse_on) begin
        case (act_d.mode)
          RR:      ctrl_hld_d[gi] = (rr_d == RR_W'(gi));
          GATED:   ctrl_hld_d[gi] = !divm_d;
          default: ctrl_hld_d[gi] = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      act_q      <= '{mode: BCAST, div: DIV_W'(MIN_DIV), pw: '0};
      pend_cfg_q <= '{mode: BCAST, div: '0, pw: '0};
      pend_q     <= 1'b0;
      rr_q       <= '0;
      divm_q     <= 1'b0;
      ctrl_hld_q <= '0;
      frame_q    <= 1'b0;
      cfg_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_cfg_q <= pend_cfg_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      divm_q     <= divm_d;
      ctrl_hld_q <= ctrl_hld_d;
      frame_q    <= frame_d;
      cfg_ack_q  <= cfg_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ctrl_hld = ctrl_hld_q;
  assign frame    = frame_q;
  assign cfg_ack  = cfg_ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hld_ctrl_gen.sv
// Directed bench for hld_ctrl_gen: a period-position model checked every cycle,
// plus literal expectations at hand-computed points.
module tb_hld_ctrl_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div_n;
  logic [DIV_W-1:0]  pw;
  logic              div_m;
  logic              upd;
  logic [NUM_CH-1:0] ctrl_hld;
  logic              frame;
  logic              cfg_ack;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  hld_ctrl_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .div_n    (div_n),
    .pw       (pw),
    .div_m    (div_m),
    .upd      (upd),
    .ctrl_hld (ctrl_hld),
    .frame    (frame),
    .cfg_ack  (cfg_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the current period (-1 when stopped), active and
  // pending configuration, round-robin channel and delayed div_m.
  int m_mode, m_div, m_pw, p_mode, p_div, p_pw, m_pos, m_rr;
  bit p_valid, m_divm, m_ack, model_live = 0;

  always @(posedge clk) begin
    int  period;
    bit  start, keep;
    if (!rst_n) begin
      m_mode = 0; m_div = 2; m_pw = 0; p_valid = 0;
      m_pos = -1; m_rr = 0; m_divm = 0; m_ack = 0;
    end else begin
      period = (m_div < 2) ? 2 : m_div;
      start  = (m_pos < 0) && en;
      keep   = (m_pos == period - 1) && en;
      if (upd) begin
        p_mode = mode; p_div = div_n; p_pw = pw; p_valid = 1;
      end
      m_ack = 0;
      if ((start || keep) && p_valid) begin
        if (p_mode != m_mode) m_rr = 0;
        else if (keep) m_rr = (m_rr + 1) % NUM_CH;
        m_mode = p_mode; m_div = p_div; m_pw = p_pw;
        p_valid = 0; m_ack = 1;
      end else if (keep) begin
        m_rr = (m_rr + 1) % NUM_CH;
      end
      if (start) m_pos = 0;
      else if (m_pos >= 0) m_pos = (m_pos == period - 1) ? (en ? 0 : -1) : m_pos + 1;
      m_divm = div_m;
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    int per, pwe;
    logic [NUM_CH-1:0] e_ctrl;
    if (model_live) begin
      per = (m_div < 2) ? 2 : m_div;
      pwe = (m_pw < per - 1) ? m_pw : per - 1;
      e_ctrl = '0;
      if (m_pos >= 0 && m_pos < pwe) begin
        if (m_mode == 1) e_ctrl = NUM_CH'(1 << m_rr);
        else if (m_mode == 2 && m_divm) e_ctrl = '0;
        else e_ctrl = '1;
      end
      chk("model_ctrl_hld", 32'(ctrl_hld), 32'(e_ctrl));
      chk("model_frame", 32'(frame), 32'(m_pos == 0));
      chk("model_cfg_ack", 32'(cfg_ack), 32'(m_ack));
      chk("model_busy", 32'(busy), 32'(m_pos >= 0));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [1:0] md, input int dn, input int p);
    mode = md; div_n = DIV_W'(dn); pw = DIV_W'(p); upd = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; div_n = '0; pw = '0; div_m = 1'b0; upd = 1'b0;

    // Reset held with en high.
    step(3);
    chk("rst_ctrl", 32'(ctrl_hld), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step();
    chk("start_frame", 32'(frame), 32'h1);
    chk("start_busy", 32'(busy), 32'h1);
    en = 1'b0;
    step(4);

    // Broadcast, period 4, width 1.
    load(2'b00, 4, 1); step(); upd = 1'b0;
    en = 1'b1; step();
    chk("bc_ctrl0", 32'(ctrl_hld), 32'hf);
    chk("bc_ack0", 32'(cfg_ack), 32'h1);
    step();
    chk("bc_ctrl1", 32'(ctrl_hld), 32'h0);
    step(3);
    chk("bc_ctrl4", 32'(ctrl_hld), 32'hf);
    chk("bc_frame4", 32'(frame), 32'h1);
    en = 1'b0; step(6);

    // Round-robin, period 3, width 2.
    load(2'b01, 3, 2); step(); upd = 1'b0;
    en = 1'b1; step();
    chk("rr_c0", 32'(ctrl_hld), 32'h1);
    step(2);
    chk("rr_c2", 32'(ctrl_hld), 32'h0);
    step();
    chk("rr_c3", 32'(ctrl_hld), 32'h2);
    step(3);
    chk("rr_c6", 32'(ctrl_hld), 32'h4);
    step(3);
    chk("rr_c9", 32'(ctrl_hld), 32'h8);
    step(3);
    chk("rr_c12", 32'(ctrl_hld), 32'h1);
    en = 1'b0; step(5);

    // Gated, period 5, width 3; div_m high just before the second period.
    load(2'b10, 5, 3); step(); upd = 1'b0;
    en = 1'b1; step();
    chk("gt_c0", 32'(ctrl_hld), 32'hf);
    step(4);
    div_m = 1'b1; step();
    chk("gt_c5_ctrl", 32'(ctrl_hld), 32'h0);
    chk("gt_c5_frame", 32'(frame), 32'h1);
    div_m = 1'b0; step();
    chk("gt_c6", 32'(ctrl_hld), 32'hf);
    step();
    chk("gt_c7", 32'(ctrl_hld), 32'hf);
    step();
    chk("gt_c8", 32'(ctrl_hld), 32'h0);

    // Width clamp: pw=15 on period 5 gives 4 high, 1 low.
    load(2'b00, 5, 15); step(); upd = 1'b0;
    step();
    chk("clamp_ack", 32'(cfg_ack), 32'h1);
    chk("clamp_c0", 32'(ctrl_hld), 32'hf);
    step(3);
    chk("clamp_c3", 32'(ctrl_hld), 32'hf);
    step();
    chk("clamp_c4", 32'(ctrl_hld), 32'h0);

    // div_n=0 clamps to period 2; strobe coincides with the boundary.
    load(2'b00, 0, 1); step(); upd = 1'b0;
    chk("div0_ack", 32'(cfg_ack), 32'h1);
    chk("div0_c0", 32'(ctrl_hld), 32'hf);
    step();
    chk("div0_c1", 32'(ctrl_hld), 32'h0);
    step();
    chk("div0_c2_frame", 32'(frame), 32'h1);
    en = 1'b0; step(4);

    // Mid-period update: last of two strobes wins at the next boundary.
    load(2'b00, 4, 2); step(); upd = 1'b0;
    en = 1'b1; step();
    step();
    load(2'b00, 7, 1); step();
    load(2'b00, 6, 3); step(); upd = 1'b0;
    chk("mid_c3_ack", 32'(cfg_ack), 32'h0);
    step();
    chk("mid_c4_ack", 32'(cfg_ack), 32'h1);
    chk("mid_c4_ctrl", 32'(ctrl_hld), 32'hf);
    step(5);
    chk("mid_c9_frame", 32'(frame), 32'h0);
    step();
    chk("mid_c10_frame", 32'(frame), 32'h1);

    // Stop at cnt=1 drains the period, then a restart and a resumed drain.
    step();
    en = 1'b0; step();
    chk("drain_c2_busy", 32'(busy), 32'h1);
    step(3);
    chk("drain_c5_busy", 32'(busy), 32'h1);
    step();
    chk("drain_end_busy", 32'(busy), 32'h0);
    chk("drain_end_ctrl", 32'(ctrl_hld), 32'h0);
    en = 1'b1; step();
    step();
    en = 1'b0; step();
    en = 1'b1; step();
    step(2);
    step();
    chk("resume_frame", 32'(frame), 32'h1);
    chk("resume_ctrl", 32'(ctrl_hld), 32'hf);

    // Reset mid-pulse clears at that same edge.
    rst_n = 1'b0; step();
    chk("rst_mid_ctrl", 32'(ctrl_hld), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    rst_n = 1'b1; en = 1'b0; step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
